dispense_arbiter: RTL and testbench

DISPENSE_ARBITER -- requirements
Module: dispense_arbiter

---
 rtl/dispense_arbiter.sv | 134 +++++++++++++
 tb/tb_dispense_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dispense_arbiter.sv
// Round-robin arbiter granting NREQ vending panels access to one shared dispenser.
// Latency: req in IDLE -> disp_start two cycles later; done/err pulse in the deciding cycle.
// Backpressure: panels hold req until done_out/err_out; one owner at a time, TMO-cycle completion timeout.
module dispense_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] sel,
    input  logic              disp_done,
    output logic [NREQ-1:0]   grant,
    output logic              disp_start,
    output logic [1:0]        disp_bev,
    output logic [NREQ-1:0]   done_out,
    output logic [NREQ-1:0]   err_out,
    output logic              busy_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   win_r, win_nxt;
    logic [PW-1:0]   win_c;
    logic            win_vld;
    logic [1:0]      win_sel;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [1:0]      bev_nxt;

    // Scan from ptr+1 upward with wrap; the first asserted request wins.
    always_comb begin
        int idx;
        win_c   = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_c   = PW'(idx);
            end
        end
    end

    assign win_sel  = sel[2*int'(win_c) +: 2];
    assign busy_out = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= PW'(NREQ - 1);
            win_r    <= '0;
            cnt      <= '0;
            grant    <= '0;
            disp_bev <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            win_r    <= win_nxt;
            cnt      <= cnt_nxt;
            grant    <= grant_nxt;
            disp_bev <= bev_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        win_nxt    = win_r;
        cnt_nxt    = cnt;
        grant_nxt  = grant;
        bev_nxt    = disp_bev;
        disp_start = 1'b0;
        done_out   = '0;
        err_out    = '0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = GRANT;
            end
            GRANT: begin
                if (!win_vld) begin
                    state_nxt = IDLE;
                end else if (win_sel == 2'b01 || win_sel == 2'b10) begin
                    grant_nxt        = '0;
                    grant_nxt[win_c] = 1'b1;
                    bev_nxt          = win_sel;
                    win_nxt          = win_c;
                    state_nxt        = START;
                end else begin
                    err_out[win_c] = 1'b1;
                    ptr_nxt        = win_c;
                    state_nxt      = RELEASE;
                end
            end
            START: begin
                disp_start = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A completion in the final timeout cycle still counts as success.
                if (disp_done) begin
                    done_out[win_r] = 1'b1;
                    ptr_nxt         = win_r;
                    state_nxt       = RELEASE;
                end else if (cnt == CW'(TMO - 1)) begin
                    err_out[win_r] = 1'b1;
                    ptr_nxt        = win_r;
                    state_nxt      = RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                grant_nxt = '0;
                bev_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed bench for dispense_arbiter: inputs driven on the falling edge, outputs checked 1 ns later.
module tb_dispense_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [7:0]      sel;
    logic            disp_done;
    logic [3:0]      grant;
    logic            disp_start;
    logic [1:0]      disp_bev;
    logic [3:0]      done_out;
    logic [3:0]      err_out;
    logic            busy_out;

    int n_chk = 0;
    int n_err = 0;

    dispense_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sel        (sel),
        .disp_done  (disp_done),
        .grant      (grant),
        .disp_start (disp_start),
        .disp_bev   (disp_bev),
        .done_out   (done_out),
        .err_out    (err_out),
        .busy_out   (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [7:0] s, input logic d);
        @(negedge clk);
        req       = r;
        sel       = s;
        disp_done = d;
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        rst = 1'b0; req = '0; sel = '0; disp_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_start", disp_start, 0);
        chk("rst_bev", disp_bev, 0);
        chk("rst_done_err", {done_out, err_out}, 0);
        rst = 1'b1;

        // Fairness: all panels requesting, served 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            cyc(4'hF, 8'hAA, 1'b0);
            chk("fair_idle_grant", grant, 0);
            chk("fair_idle_busy", busy_out, 0);
            cyc(4'hF, 8'hAA, 1'b0);
            cyc(4'hF, 8'hAA, 1'b0);
            chk("fair_grant", grant, exp_g);
            chk("fair_start", disp_start, 1);
            chk("fair_bev", disp_bev, 2'b10);
            cyc(4'hF, 8'hAA, 1'b1);
            chk("fair_done", done_out, exp_g);
            cyc(4'hF, 8'hAA, 1'b0);
        end
        cyc(4'h0, 8'h00, 1'b1);
        chk("stray_done", done_out, 0);
        chk("stray_busy", busy_out, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("stray_busy2", busy_out, 0);

        // Single request, completion three cycles after disp_start.
        cyc(4'h1, 8'h01, 1'b0);
        chk("single_idle_busy", busy_out, 0);
        cyc(4'h1, 8'h01, 1'b0);
        chk("single_gnt_busy", busy_out, 1);
        chk("single_gnt_grant", grant, 0);
        cyc(4'h1, 8'h01, 1'b0);
        chk("single_start", disp_start, 1);
        chk("single_grant", grant, 4'b0001);
        chk("single_bev", disp_bev, 2'b01);
        cyc(4'h1, 8'h02, 1'b0);
        chk("single_start_pulse", disp_start, 0);
        chk("single_bev_held", disp_bev, 2'b01);
        cyc(4'h1, 8'h02, 1'b0);
        cyc(4'h1, 8'h02, 1'b1);
        chk("single_done", done_out, 4'b0001);
        chk("single_err", err_out, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("single_rel_done", done_out, 0);
        chk("single_rel_busy", busy_out, 1);
        cyc(4'h0, 8'h00, 1'b0);
        chk("single_end_busy", busy_out, 0);
        chk("single_end_grant", grant, 0);
        chk("single_end_bev", disp_bev, 0);

        // Invalid beverage code on panel 2.
        cyc(4'h4, 8'h30, 1'b0);
        cyc(4'h4, 8'h30, 1'b0);
        chk("inv_err", err_out, 4'b0100);
        chk("inv_start", disp_start, 0);
        chk("inv_grant", grant, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("inv_rel_err", err_out, 0);
        chk("inv_rel_grant", grant, 0);
        chk("inv_rel_start", disp_start, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("inv_end_busy", busy_out, 0);

        // Timeout on panel 1; req drop during WAIT is ignored.
        cyc(4'h2, 8'h04, 1'b0);
        cyc(4'h2, 8'h04, 1'b0);
        cyc(4'h2, 8'h04, 1'b0);
        chk("tmo_start", disp_start, 1);
        chk("tmo_grant", grant, 4'b0010);
        for (int k = 1; k <= TMO; k++) begin
            cyc((k >= 5) ? 4'h0 : 4'h2, 8'h04, 1'b0);
            if (k == 5) chk("tmo_drop_grant", grant, 4'b0010);
            if (k < TMO) chk("tmo_early_err", err_out, 0);
            else begin
                chk("tmo_err", err_out, 4'b0010);
                chk("tmo_no_done", done_out, 0);
            end
        end
        cyc(4'h0, 8'h00, 1'b0);
        chk("tmo_rel_err", err_out, 0);
        cyc(4'h0, 8'h00, 1'b0);

        // Completion coincident with the final timeout cycle.
        cyc(4'h2, 8'h04, 1'b0);
        cyc(4'h2, 8'h04, 1'b0);
        cyc(4'h2, 8'h04, 1'b0);
        chk("edge_grant", grant, 4'b0010);
        for (int k = 1; k <= TMO; k++) begin
            cyc(4'h2, 8'h04, (k == TMO));
            if (k == TMO) begin
                chk("edge_done", done_out, 4'b0010);
                chk("edge_no_err", err_out, 0);
            end
        end
        cyc(4'h0, 8'h00, 1'b0);
        cyc(4'h0, 8'h00, 1'b0);

        // Reset during WAIT, then pointer restarts at panel 0.
        cyc(4'h4, 8'h20, 1'b0);
        cyc(4'h4, 8'h20, 1'b0);
        cyc(4'h4, 8'h20, 1'b0);
        chk("rmid_grant", grant, 4'b0100);
        cyc(4'h4, 8'h20, 1'b0);
        cyc(4'h4, 8'h20, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rmid_grant0", grant, 0);
        chk("rmid_busy0", busy_out, 0);
        chk("rmid_bev0", disp_bev, 0);
        chk("rmid_pulses0", {disp_start, done_out, err_out}, 0);
        cyc(4'h0, 8'h00, 1'b0);
        cyc(4'h0, 8'h00, 1'b0);
        rst = 1'b1;
        cyc(4'hA, 8'h44, 1'b0);
        cyc(4'hA, 8'h44, 1'b0);
        cyc(4'hA, 8'h44, 1'b0);
        chk("rmid_ptr_grant", grant, 4'b0010);
        cyc(4'hA, 8'h44, 1'b1);
        chk("rmid_done", done_out, 4'b0010);
        cyc(4'h0, 8'h00, 1'b0);
        cyc(4'h0, 8'h00, 1'b0);

        // Request dropped in the GRANT cycle.
        cyc(4'h1, 8'h01, 1'b0);
        cyc(4'h0, 8'h01, 1'b0);
        chk("drop_pulses", {done_out, err_out}, 0);
        chk("drop_grant", grant, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("drop_busy", busy_out, 0);
        chk("drop_grant2", grant, 0);
        chk("drop_start", disp_start, 0);
        cyc(4'h0, 8'h00, 1'b0);
        chk("drop_grant3", grant, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
